// File: rtl/down_counter_reload.sv
// down_counter_reload: synchronous down counter with parallel load, count enable,
// optional auto-reload, one-cycle terminal-count pulse and busy flag.
module down_counter_reload #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] Q,
   output logic             tc,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t           state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
   logic             tc_q, tc_d, busy_q, busy_d;
   logic             dec, term;
   assign dec  = state_q == RUN && en && !load;
   assign term = dec && cnt_q == WIDTH'(1);
   always_comb begin
      cnt_d    = load ? load_val
               : term ? (auto_reload ? reload_q : '0)
               : (dec && cnt_q > WIDTH'(1)) ? cnt_q - WIDTH'(1) : cnt_q;
      reload_d = load ? load_val : reload_q;
      state_d  = load ? (load_val != '0 ? RUN : IDLE)
               : (term && !auto_reload) ? DONE : state_q;
      tc_d     = term;
      busy_d   = state_d == RUN;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         tc_q     <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         tc_q     <= tc_d;
         busy_q   <= busy_d;
      end
   end
   assign Q    = cnt_q;
   assign tc   = tc_q;
   assign busy = busy_q;
endmodule

// File: tb/tb_down_counter_reload.sv
// tb_down_counter_reload: scoreboard bench; a driver pushes model predictions,
// a monitor pops and compares them just after every rising edge.
module tb_down_counter_reload;
   localparam int W = 4;
   logic         clk = 1'b0, rst = 1'b1, load = 1'b0, en = 1'b0, auto_reload = 1'b0;
   logic [W-1:0] load_val = '0;
   logic [W-1:0] Q;
   logic         tc, busy;
   typedef struct {logic [W-1:0] q; logic tc; logic busy;} exp_t;
   exp_t sb[$];
   int   tests = 0, fails = 0;
   int   m_q = 0, m_rel = 0;
   bit   m_run = 0, m_tc = 0;
   down_counter_reload #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .en(en),
      .auto_reload(auto_reload), .Q(Q), .tc(tc), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s at %0t: got %0d expected %0d", n, $time, act, want);
      end
   endtask
   // Model: a run flag, the remaining count and the reload value.
   task automatic step(input bit ld, input int val, input bit e, input bit ar);
      @(negedge clk);
      load = ld; load_val = W'(val); en = e; auto_reload = ar;
      m_tc = 0;
      if (ld) begin
         m_q = val; m_rel = val; m_run = (val != 0);
      end else if (m_run && e) begin
         if (m_q == 1) begin
            m_tc = 1;
            if (ar) m_q = m_rel;
            else begin m_q = 0; m_run = 0; end
         end else m_q = m_q - 1;
      end
      sb.push_back('{q: W'(m_q), tc: m_tc, busy: m_run});
   endtask
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk("Q", 16'(Q), 16'(e.q));
         chk("tc", 16'(tc), 16'(e.tc));
         chk("busy", 16'(busy), 16'(e.busy));
      end
   end
   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_Q", 16'(Q), 16'd0);
      chk("rst_tc", 16'(tc), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      rst = 1'b0;
      repeat (3) step(0, 0, 1, 0);
      step(1, 5, 1, 0);
      repeat (15) step(0, 0, 1, 0);
      step(1, 3, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 0, 0); step(0, 0, 0, 0);
      step(0, 0, 1, 0); step(0, 0, 1, 0); step(0, 0, 1, 0);
      step(1, 3, 0, 1);
      repeat (12) step(0, 0, 1, 1);
      step(1, 5, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      step(1, 9, 1, 0);
      step(0, 0, 1, 0);
      step(1, 0, 1, 0);
      repeat (2) step(0, 0, 1, 0);
      step(1, 15, 0, 0);
      repeat (18) step(0, 0, 1, 0);
      step(1, 1, 0, 0);
      repeat (3) step(0, 0, 1, 0);
      step(1, 1, 0, 1);
      repeat (3) step(0, 0, 1, 1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) == 0, $urandom_range(0, 15),
              $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      step(1, 7, 0, 0);
      step(0, 0, 0, 0);
      @(negedge clk);
      load = 1'b0; en = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("async_Q", 16'(Q), 16'd0);
      chk("async_tc", 16'(tc), 16'd0);
      chk("async_busy", 16'(busy), 16'd0);
      @(negedge clk);
      rst = 1'b0;
      m_q = 0; m_rel = 0; m_run = 0;
      repeat (4) step(0, 0, 1, 1);
      repeat (2) @(negedge clk);
      chk("sb_empty", 16'(sb.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/down_counter_reload.md
Name: down_counter_reload

Overview:
Synchronous, parameterised down counter with parallel load, count enable and optional auto-reload. It is the counting-down counterpart of the team's up-counting ripple counters. Unlike them, every flop is clocked by the single system clock, so all outputs are glitch-free and usable as timers or period generators. It produces a one-cycle terminal-count pulse and a busy flag for downstream control logic.

Parameters:
WIDTH, 4, bit width of the count and load value (valid range 2..16).

Ports:
clk  input  1  system clock, all flops rising-edge.
rst  input  1  asynchronous active-high reset.
load  input  1  parallel load strobe, sampled on clk rising edge.
load_val  input  WIDTH  value loaded into count and reload register when load=1.
en  input  1  count enable; one decrement per clk edge with en=1 while running.
auto_reload  input  1  1 = restart from reload value at terminal; 0 = one-shot.
Q  output  WIDTH  current count, registered.
tc  output  1  terminal-count pulse, registered, one cycle wide.
busy  output  1  1 while state is RUN, registered.

Behaviour:
- Reset: rst=1 clears immediately, independent of clk.
  - Q=0, internal reload_reg=0, tc=0, busy=0, state=IDLE.
  - Reset asserted mid-count aborts the run with no tc pulse.
  - After rst deasserts, the block stays in IDLE until load.
- States: IDLE, RUN, DONE. busy=1 only in RUN. tc defaults to 0 every cycle unless set below.
- Load (any state; priority over en):
  - Q<=load_val and reload_reg<=load_val.
  - If load_val!=0: state<=RUN. If load_val==0: state<=IDLE.
  - tc=0 in the load cycle. A load during RUN restarts the count with no tc pulse.
- RUN, en=0, load=0: Q holds, state holds.
- RUN, en=1, Q>1: Q<=Q-1.
- RUN, en=1, Q==1, auto_reload=0 (one-shot):
  - Q<=0, state<=DONE, tc<=1 for exactly one cycle, coinciding with the first cycle Q==0.
- RUN, en=1, Q==1, auto_reload=1:
  - Q<=reload_reg, state stays RUN, tc<=1 for one cycle, coinciding with Q showing reload_reg.
  - Period is exactly reload_reg enabled clocks; Q never shows 0.
- auto_reload is sampled only at the Q==1 & en decision edge. Changing it mid-count has no other effect.
- IDLE/DONE: Q holds (0 in DONE). en is ignored, tc=0. Only load leaves these states.
- Widths and boundaries:
  - No underflow: the counter never decrements from 0.
  - Maximum load 2^WIDTH-1 is counted fully (15 cycles to terminal for WIDTH=4).
  - load_val==1 gives tc on the first enabled edge.
- Latency: Q reflects load_val one clk after the load edge. tc and busy are registered and are not combinational from inputs.

Test Plan:
- Reset: assert rst mid-cycle with Q=7 -> Q=0, tc=0, busy=0 immediately, without waiting for a clk edge; en pulses with no load afterwards keep Q=0.
- One-shot: load_val=5, auto_reload=0, en=1 continuous -> Q=5,4,3,2,1,0; tc=1 only in the cycle Q=0; busy falls with it; Q stays 0 for 10 more cycles.
- Enable gaps: load_val=3, en toggling 1,0,0,1,1 -> Q=3,2,2,2,1,0; tc once at Q=0.
- Auto-reload: load_val=3, auto_reload=1, en=1 for 12 cycles -> Q=3,2,1,3,2,1,...; tc every 3rd cycle (4 pulses); busy stays 1.
- Load priority and restart: during RUN at Q=2 drive load=1, en=1, load_val=9 -> Q=9 next cycle, no tc; load_val=0 -> Q=0, state IDLE, busy=0, no tc.
- Width boundary (WIDTH=4): load_val=15, one-shot -> exactly 15 enabled edges to Q=0; tc once; no wrap to 15.
